// File: rtl/vending_pkg.sv
// Coin codes, coin values and dispenser state encoding
// shared across the vending coin path.
package vending_pkg;

   typedef enum logic [1:0] {
      COIN_NONE = 2'b00,
      COIN_1    = 2'b01,
      COIN_2    = 2'b10,
      COIN_5    = 2'b11
   } coin_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_PAY,
      ST_DONE,
      ST_FAULT
   } disp_state_t;

   function automatic logic [3:0] coin_value(input coin_t c);
      logic [3:0] v;
      case (c)
         COIN_1:  v = 4'd1;
         COIN_2:  v = 4'd2;
         COIN_5:  v = 4'd5;
         default: v = 4'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin stock: saturating refill,
// consume on hopper ack; a refill and consume together cancel.
module coin_inventory
   import vending_pkg::*;
#(
   parameter int CNT_W      = 6,
   parameter int INIT_CNT_1 = 10,
   parameter int INIT_CNT_2 = 10,
   parameter int INIT_CNT_5 = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             refill_valid_i,
   input  coin_t            refill_coin_i,
   input  logic             consume_valid_i,
   input  coin_t            consume_coin_i,
   output logic [CNT_W-1:0] cnt_1_o,
   output logic [CNT_W-1:0] cnt_2_o,
   output logic [CNT_W-1:0] cnt_5_o
);

   localparam logic [CNT_W-1:0] MAX = '1;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_1_q, cnt_1_d;
   logic [CNT_W-1:0] cnt_2_q, cnt_2_d;
   logic [CNT_W-1:0] cnt_5_q, cnt_5_d;

   function automatic logic [CNT_W-1:0] step(
      input logic [CNT_W-1:0] c,
      input logic             inc,
      input logic             dec
   );
      logic [CNT_W-1:0] r;
      r = c;
      if (inc && !dec && c != MAX)
         r = c + ONE;
      else if (dec && !inc && c != '0)
         r = c - ONE;
      return r;
   endfunction

   always_comb begin
      cnt_1_d = step(cnt_1_q,
         refill_valid_i && refill_coin_i == COIN_1,
         consume_valid_i && consume_coin_i == COIN_1);
      cnt_2_d = step(cnt_2_q,
         refill_valid_i && refill_coin_i == COIN_2,
         consume_valid_i && consume_coin_i == COIN_2);
      cnt_5_d = step(cnt_5_q,
         refill_valid_i && refill_coin_i == COIN_5,
         consume_valid_i && consume_coin_i == COIN_5);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_1_q <= CNT_W'(INIT_CNT_1);
         cnt_2_q <= CNT_W'(INIT_CNT_2);
         cnt_5_q <= CNT_W'(INIT_CNT_5);
      end else begin
         cnt_1_q <= cnt_1_d;
         cnt_2_q <= cnt_2_d;
         cnt_5_q <= cnt_5_d;
      end
   end

   assign cnt_1_o = cnt_1_q;
   assign cnt_2_o = cnt_2_q;
   assign cnt_5_o = cnt_5_q;

endmodule

// File: rtl/change_dispenser.sv
// Pays out change largest coin first, one coin per
// hopper handshake, with shortfall and ack-timeout reporting.
module change_dispenser
   import vending_pkg::*;
#(
   parameter int CNT_W       = 6,
   parameter int INIT_CNT_1  = 10,
   parameter int INIT_CNT_2  = 10,
   parameter int INIT_CNT_5  = 10,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             change_valid,
   input  logic [3:0]       change_amt,
   output logic [1:0]       coin_out,
   output logic             coin_valid,
   input  logic             coin_ack,
   input  logic             refill_valid,
   input  logic [1:0]       refill_coin,
   input  logic             fault_clr,
   output logic             busy,
   output logic             done,
   output logic             short,
   output logic [3:0]       shortfall,
   output logic             fault,
   output logic             overrun,
   output logic [CNT_W-1:0] cnt_1,
   output logic [CNT_W-1:0] cnt_2,
   output logic [CNT_W-1:0] cnt_5
);

   localparam int          TW   = $clog2(ACK_TIMEOUT);
   localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);

   disp_state_t   state_q, state_d;
   logic [3:0]    rem_q, rem_d;
   logic [3:0]    shortfall_q, shortfall_d;
   logic [TW-1:0] timer_q, timer_d;
   coin_t         sel_q, sel_d;
   coin_t         pick;
   logic          ack_pay;

   assign ack_pay = (state_q == ST_PAY) && coin_ack;

   coin_inventory #(
      .CNT_W      (CNT_W),
      .INIT_CNT_1 (INIT_CNT_1),
      .INIT_CNT_2 (INIT_CNT_2),
      .INIT_CNT_5 (INIT_CNT_5)
   ) u_inv (
      .clk             (clk),
      .reset_n         (reset_n),
      .refill_valid_i  (refill_valid),
      .refill_coin_i   (coin_t'(refill_coin)),
      .consume_valid_i (ack_pay),
      .consume_coin_i  (sel_q),
      .cnt_1_o         (cnt_1),
      .cnt_2_o         (cnt_2),
      .cnt_5_o         (cnt_5)
   );

   // Greedy pick against live stock
   always_comb begin
      pick = COIN_NONE;
      if (rem_q >= 4'd5 && cnt_5 != '0)
         pick = COIN_5;
      else if (rem_q >= 4'd2 && cnt_2 != '0)
         pick = COIN_2;
      else if (rem_q != 4'd0 && cnt_1 != '0)
         pick = COIN_1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         shortfall_q <= '0;
         timer_q     <= '0;
         sel_q       <= COIN_NONE;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         shortfall_q <= shortfall_d;
         timer_q     <= timer_d;
         sel_q       <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (change_valid)
               state_d = (change_amt == 4'd0) ? ST_DONE : ST_SELECT;
         ST_SELECT:
            state_d = (pick == COIN_NONE) ? ST_DONE : ST_PAY;
         ST_PAY:
            if (coin_ack)
               state_d = (rem_q == coin_value(sel_q)) ? ST_DONE : ST_SELECT;
            else if (timer_q == TMAX)
               state_d = ST_FAULT;
         ST_DONE:
            state_d = ST_IDLE;
         ST_FAULT:
            if (fault_clr)
               state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rem_d   = rem_q;
      sel_d   = sel_q;
      timer_d = '0;
      if (state_q == ST_IDLE && change_valid)
         rem_d = change_amt;
      if (state_q == ST_SELECT)
         sel_d = pick;
      if (ack_pay)
         rem_d = rem_q - coin_value(sel_q);
      if (state_q == ST_PAY && !coin_ack)
         timer_d = timer_q + TW'(1);
      if (state_q == ST_FAULT && fault_clr)
         rem_d = '0;
      shortfall_d = (state_d == ST_DONE) ? rem_d : shortfall_q;
   end

   always_comb begin
      busy       = (state_q != ST_IDLE);
      done       = (state_q == ST_DONE);
      fault      = (state_q == ST_FAULT);
      coin_valid = (state_q == ST_PAY);
      coin_out   = coin_valid ? sel_q : COIN_NONE;
      short      = done && (shortfall_q != 4'd0);
      shortfall  = shortfall_q;
      overrun    = change_valid && (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: greedy coin model,
// hopper responder, timeout, refill and reset scenarios.
module tb_change_dispenser;
   import vending_pkg::*;

   localparam int CNT_W  = 6;
   localparam int ACK_TO = 16;
   localparam int CMAX   = 63;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             change_valid = 1'b0;
   logic [3:0]       change_amt = 4'd0;
   logic [1:0]       coin_out;
   logic             coin_valid;
   logic             coin_ack = 1'b0;
   logic             refill_valid = 1'b0;
   logic [1:0]       refill_coin = 2'b00;
   logic             fault_clr = 1'b0;
   logic             busy, done, short_s, fault, overrun;
   logic [3:0]       shortfall;
   logic [CNT_W-1:0] cnt_1, cnt_2, cnt_5;

   int errors = 0;
   int checks = 0;
   int m1, m2, m5;
   logic [1:0] exp_q[$];

   change_dispenser #(
      .CNT_W(CNT_W), .INIT_CNT_1(10), .INIT_CNT_2(10),
      .INIT_CNT_5(10), .ACK_TIMEOUT(ACK_TO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .change_valid(change_valid), .change_amt(change_amt),
      .coin_out(coin_out), .coin_valid(coin_valid),
      .coin_ack(coin_ack), .refill_valid(refill_valid),
      .refill_coin(refill_coin), .fault_clr(fault_clr),
      .busy(busy), .done(done), .short(short_s),
      .shortfall(shortfall), .fault(fault), .overrun(overrun),
      .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_5(cnt_5)
   );

   always #5 clk = ~clk;

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, short_s, fault, overrun, coin_valid, coin_out, shortfall} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 0",
            {busy, done, short_s, fault, overrun, coin_valid, coin_out, shortfall});
      end
      checks++;
      if ({cnt_5, cnt_2, cnt_1} !== {6'd10, 6'd10, 6'd10}) begin
         errors++;
         $display("FAIL reset_stock: got %0d/%0d/%0d want 10/10/10", cnt_5, cnt_2, cnt_1);
      end
      reset_n = 1'b1;
      m1 = 10; m2 = 10; m5 = 10;
      @(negedge clk);
   endtask

   task automatic do_payout(input int amt, input bit ovr, input bit rfl, input string nm);
      int rem, cyc, first, ncoin;
      bit fin;
      logic [1:0] c;
      logic [3:0] exp_sf;
      rem = amt;
      while (1) begin
         if (rem >= 5 && m5 > 0) begin exp_q.push_back(2'b11); m5--; rem -= 5; end
         else if (rem >= 2 && m2 > 0) begin exp_q.push_back(2'b10); m2--; rem -= 2; end
         else if (rem >= 1 && m1 > 0) begin exp_q.push_back(2'b01); m1--; rem -= 1; end
         else break;
      end
      exp_sf = 4'(rem);
      ncoin = exp_q.size();
      change_valid = 1'b1;
      change_amt = 4'(amt);
      cyc = 0; first = -1; fin = 1'b0;
      while (!fin && cyc < 100) begin
         @(negedge clk);
         cyc++;
         change_valid = 1'b0;
         coin_ack = 1'b0;
         refill_valid = 1'b0;
         refill_coin = 2'b00;
         if (coin_valid) begin
            if (first < 0) first = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s_extra_coin: got coin %b want none", nm, coin_out);
            end else begin
               c = exp_q.pop_front();
               if (coin_out !== c) begin
                  errors++;
                  $display("FAIL %s_coin: got %b want %b", nm, coin_out, c);
               end
            end
            coin_ack = 1'b1;
            if (rfl && coin_out == 2'b10) begin
               refill_valid = 1'b1;
               refill_coin = 2'b10;
               m2++;
            end
         end
         if (done) begin
            fin = 1'b1;
            checks++;
            if ({short_s, shortfall} !== {exp_sf != 4'd0, exp_sf}) begin
               errors++;
               $display("FAIL %s_short: got short=%b sf=%0d want short=%b sf=%0d",
                  nm, short_s, shortfall, exp_sf != 4'd0, exp_sf);
            end
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL %s_missing_coins: got %0d left want 0", nm, exp_q.size());
            end
         end
         if (ovr && cyc == 1) begin
            change_valid = 1'b1;
            change_amt = 4'd4;
            #1;
            checks++;
            if (overrun !== 1'b1) begin
               errors++;
               $display("FAIL %s_overrun: got %b want 1", nm, overrun);
            end
         end
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL %s_timeout: got no done want done within 100 cycles", nm);
      end
      if (ncoin > 0) begin
         checks++;
         if (first !== 2) begin
            errors++;
            $display("FAIL %s_latency: got %0d want 2", nm, first);
         end
      end
      checks++;
      if ({cnt_5, cnt_2, cnt_1} !== {CNT_W'(m5), CNT_W'(m2), CNT_W'(m1)}) begin
         errors++;
         $display("FAIL %s_stock: got %0d/%0d/%0d want %0d/%0d/%0d",
            nm, cnt_5, cnt_2, cnt_1, m5, m2, m1);
      end
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_full_stock;
      do_payout(8, 1'b0, 1'b0, "full8");
   endtask

   task automatic test_zero;
      do_payout(0, 1'b0, 1'b0, "zero");
   endtask

   task automatic test_back_to_back;
      while (m1 > 0) do_payout(1, 1'b0, 1'b0, "drain1");
   endtask

   task automatic test_short;
      do_payout(3, 1'b0, 1'b0, "short3");
   endtask

   task automatic test_overrun;
      do_payout(7, 1'b1, 1'b0, "ovr7");
   endtask

   task automatic test_refill;
      do_payout(2, 1'b0, 1'b1, "collide2");
      refill_valid = 1'b1;
      refill_coin = 2'b00;
      @(negedge clk);
      refill_valid = 1'b0;
      checks++;
      if ({cnt_5, cnt_2, cnt_1} !== {CNT_W'(m5), CNT_W'(m2), CNT_W'(m1)}) begin
         errors++;
         $display("FAIL refill_none: got %0d/%0d/%0d want %0d/%0d/%0d",
            cnt_5, cnt_2, cnt_1, m5, m2, m1);
      end
      refill_coin = 2'b01;
      for (int i = 0; i < 70; i++) begin
         refill_valid = 1'b1;
         if (m1 < CMAX) m1++;
         @(negedge clk);
      end
      refill_valid = 1'b0;
      refill_coin = 2'b00;
      checks++;
      if (cnt_1 !== CNT_W'(m1)) begin
         errors++;
         $display("FAIL refill_saturate: got %0d want %0d", cnt_1, m1);
      end
   endtask

   task automatic test_timeout;
      int n, bad, cyc;
      change_valid = 1'b1;
      change_amt = 4'd2;
      n = 0; bad = 0; cyc = 0;
      while (cyc < 60) begin
         @(negedge clk);
         cyc++;
         change_valid = 1'b0;
         if (coin_valid) begin
            n++;
            if (coin_out !== 2'b10) bad++;
         end else if (fault) begin
            break;
         end
      end
      checks++;
      if (n != ACK_TO || bad != 0) begin
         errors++;
         $display("FAIL timeout_len: got %0d cycles (%0d unstable) want %0d", n, bad, ACK_TO);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({fault, busy, coin_valid, coin_out, done} !== 6'b110000) begin
         errors++;
         $display("FAIL timeout_fault: got %b want 110000",
            {fault, busy, coin_valid, coin_out, done});
      end
      checks++;
      if ({cnt_5, cnt_2, cnt_1} !== {CNT_W'(m5), CNT_W'(m2), CNT_W'(m1)}) begin
         errors++;
         $display("FAIL timeout_stock: got %0d/%0d/%0d want %0d/%0d/%0d",
            cnt_5, cnt_2, cnt_1, m5, m2, m1);
      end
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      checks++;
      if ({busy, fault} !== 2'b00) begin
         errors++;
         $display("FAIL fault_clr: got busy/fault=%b want 00", {busy, fault});
      end
   endtask

   task automatic test_reset_mid_pay;
      int cyc;
      change_valid = 1'b1;
      change_amt = 4'd5;
      cyc = 0;
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
         change_valid = 1'b0;
         if (coin_valid) break;
      end
      checks++;
      if (coin_valid !== 1'b1) begin
         errors++;
         $display("FAIL midpay_start: got coin_valid=%b want 1", coin_valid);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, short_s, fault, coin_valid, coin_out, shortfall} !== 10'd0) begin
         errors++;
         $display("FAIL midpay_reset_out: got %b want 0",
            {busy, done, short_s, fault, coin_valid, coin_out, shortfall});
      end
      checks++;
      if ({cnt_5, cnt_2, cnt_1} !== {6'd10, 6'd10, 6'd10}) begin
         errors++;
         $display("FAIL midpay_reset_stock: got %0d/%0d/%0d want 10/10/10", cnt_5, cnt_2, cnt_1);
      end
      @(negedge clk);
      reset_n = 1'b1;
      m1 = 10; m2 = 10; m5 = 10;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_full_stock();
      test_zero();
      test_back_to_back();
      test_short();
      test_overrun();
      test_refill();
      test_timeout();
      test_reset_mid_pay();
      do_payout(9, 1'b0, 1'b0, "after_reset9");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
